// File: rtl/write_to_ddr3.sv
// rtl/write_to_ddr3.sv - drains a show-ahead pixel FIFO into two ping-pong DDR3 frame buffers over 4-beat Avalon-MM bursts
//
// Purpose:
//   Pulls pixel words from a show-ahead FIFO and writes whole frames into one
//   of two DDR3 frame buffers. Each burst is 4 beats and starts only when 4
//   words are buffered. When a frame's last burst completes, that buffer is
//   flagged valid for the downstream frame reader. The reader's clear pulses
//   free the buffer again. Everything runs on ddr3_clk.
//
// Optional feature (macro WR_FRAME_OVERWRITE_EN):
//   When defined and both buffers are valid, the writer takes back the buffer
//   it wrote last and overwrites it, so the input never stalls. When
//   undefined, the writer waits in IDLE until a clear pulse frees a buffer.
//
// Ports:
//   ddr3_clk, ddr3_reset                    clock, async active-high reset
//   data_fifo_q/usedw/rdreq                 show-ahead FIFO head, fill level, pop
//   ddr3_buffer0_offset/ddr3_buffer1_offset word base addresses of the two buffers
//   clear_buffer0/clear_buffer1             reader released buffer 0/1 (1-cycle)
//   ddr3_wr_buffer0_valid/1_valid           buffer holds a complete frame
//   frame_done                              1-cycle pulse after a frame's last beat
//   ddr3_avl_*                              Avalon-MM burst write master
module write_to_ddr3 #(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 1024,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_LEN    = 4
) (
    input  logic                    ddr3_clk,
    input  logic                    ddr3_reset,
    input  logic [DATA_WIDTH-1:0]   data_fifo_q,
    input  logic [11:0]             data_fifo_usedw,
    output logic                    data_fifo_rdreq,
    input  logic [25:0]             ddr3_buffer0_offset,
    input  logic [25:0]             ddr3_buffer1_offset,
    input  logic                    clear_buffer0,
    input  logic                    clear_buffer1,
    output logic                    ddr3_wr_buffer0_valid,
    output logic                    ddr3_wr_buffer1_valid,
    output logic                    frame_done,
    input  logic                    ddr3_avl_ready,
    output logic                    ddr3_avl_burstbegin,
    output logic                    ddr3_avl_write_req,
    output logic [2:0]              ddr3_avl_size,
    output logic [25:0]             ddr3_avl_addr,
    output logic [DATA_WIDTH-1:0]   ddr3_avl_wdata,
    output logic [DATA_WIDTH/8-1:0] ddr3_avl_be
);

    localparam int          FRAME_BURSTS = (IMAGE_WIDTH * IMAGE_HEIGHT) >> 2;
    localparam logic [23:0] LAST_BURST   = 24'(FRAME_BURSTS - 1);
    localparam logic [25:0] ADDR_STEP    = 26'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DATA  = 2'd1,
        BURST      = 2'd2,
        FRAME_DONE = 2'd3
    } state_t;

    state_t      state, state_n;
    logic        write_req, write_req_n;
    logic        burstbegin, burstbegin_n;
    logic [25:0] addr, addr_n;
    logic [23:0] burst_count, burst_count_n;
    logic [1:0]  beat_count, beat_count_n;
    logic        wr_sel, wr_sel_n;
    logic        last_sel, last_sel_n;
    logic [1:0]  valid, valid_n;

    logic        pref;
    logic        take;
    logic        sel;
    logic        beat_accept;

    assign beat_accept = write_req & ddr3_avl_ready;

    always_ff @(posedge ddr3_clk or posedge ddr3_reset) begin
        if (ddr3_reset) begin
            state       <= IDLE;
            write_req   <= 1'b0;
            burstbegin  <= 1'b0;
            addr        <= '0;
            burst_count <= '0;
            beat_count  <= '0;
            wr_sel      <= 1'b0;
            // Treat buffer 1 as last written so the first frame lands in buffer 0.
            last_sel    <= 1'b1;
            valid       <= 2'b00;
        end else begin
            state       <= state_n;
            write_req   <= write_req_n;
            burstbegin  <= burstbegin_n;
            addr        <= addr_n;
            burst_count <= burst_count_n;
            beat_count  <= beat_count_n;
            wr_sel      <= wr_sel_n;
            last_sel    <= last_sel_n;
            valid       <= valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        write_req_n   = write_req;
        burstbegin_n  = burstbegin;
        addr_n        = addr;
        burst_count_n = burst_count;
        beat_count_n  = beat_count;
        wr_sel_n      = wr_sel;
        last_sel_n    = last_sel;
        // Reader clears first; a set later in this block overrides a same-cycle clear.
        valid_n       = valid & ~{clear_buffer1, clear_buffer0};
        pref          = ~last_sel;
        take          = 1'b0;
        sel           = pref;

        case (state)
            IDLE: begin
                if (!valid[pref]) begin
                    take = 1'b1;
                    sel  = pref;
                end else if (!valid[~pref]) begin
                    take = 1'b1;
                    sel  = ~pref;
                end
`ifdef WR_FRAME_OVERWRITE_EN
                else begin
                    // Both pending: drop the frame written last and reuse its buffer.
                    take             = 1'b1;
                    sel              = last_sel;
                    valid_n[last_sel] = 1'b0;
                end
`endif
                if (take) begin
                    wr_sel_n      = sel;
                    addr_n        = sel ? ddr3_buffer1_offset : ddr3_buffer0_offset;
                    burst_count_n = '0;
                    state_n       = WAIT_DATA;
                end
            end

            WAIT_DATA: begin
                if (data_fifo_usedw >= 12'd4) begin
                    write_req_n  = 1'b1;
                    burstbegin_n = 1'b1;
                    beat_count_n = '0;
                    state_n      = BURST;
                end
            end

            BURST: begin
                if (beat_accept) begin
                    beat_count_n = beat_count + 2'd1;
                    burstbegin_n = 1'b0;
                    if (beat_count == 2'd3) begin
                        if (burst_count == LAST_BURST) begin
                            write_req_n = 1'b0;
                            state_n     = FRAME_DONE;
                        end else begin
                            addr_n        = addr + ADDR_STEP;
                            burst_count_n = burst_count + 24'd1;
                            // usedw still counts the word popped this cycle, so 5 means 4 remain.
                            if (data_fifo_usedw >= 12'd5) begin
                                burstbegin_n = 1'b1;
                            end else begin
                                write_req_n = 1'b0;
                                state_n     = WAIT_DATA;
                            end
                        end
                    end
                end
            end

            FRAME_DONE: begin
                valid_n[wr_sel] = 1'b1;
                last_sel_n      = wr_sel;
                state_n         = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign data_fifo_rdreq       = beat_accept;
    assign frame_done            = (state == FRAME_DONE);
    assign ddr3_wr_buffer0_valid = valid[0];
    assign ddr3_wr_buffer1_valid = valid[1];
    assign ddr3_avl_burstbegin   = burstbegin;
    assign ddr3_avl_write_req    = write_req;
    assign ddr3_avl_size         = 3'b100;
    assign ddr3_avl_addr         = addr;
    assign ddr3_avl_wdata        = data_fifo_q;
    assign ddr3_avl_be           = '1;

endmodule

// File: tb/tb_write_to_ddr3.sv
// tb/tb_write_to_ddr3.sv - self-checking bench for write_to_ddr3 with a FIFO model and a frame-level reference
module tb_write_to_ddr3;

    localparam int W           = 8;
    localparam int H           = 4;
    localparam int DW          = 32;
    localparam int FRAME_WORDS = W * H;

    logic            ddr3_clk = 1'b0;
    logic            ddr3_reset;
    logic [DW-1:0]   data_fifo_q;
    logic [11:0]     data_fifo_usedw;
    logic            data_fifo_rdreq;
    logic [25:0]     ddr3_buffer0_offset;
    logic [25:0]     ddr3_buffer1_offset;
    logic            clear_buffer0;
    logic            clear_buffer1;
    logic            ddr3_wr_buffer0_valid;
    logic            ddr3_wr_buffer1_valid;
    logic            frame_done;
    logic            ddr3_avl_ready;
    logic            ddr3_avl_burstbegin;
    logic            ddr3_avl_write_req;
    logic [2:0]      ddr3_avl_size;
    logic [25:0]     ddr3_avl_addr;
    logic [DW-1:0]   ddr3_avl_wdata;
    logic [DW/8-1:0] ddr3_avl_be;

    always #5 ddr3_clk = ~ddr3_clk;

    write_to_ddr3 #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .DATA_WIDTH  (DW),
        .BURST_LEN   (4)
    ) dut (
        .ddr3_clk             (ddr3_clk),
        .ddr3_reset           (ddr3_reset),
        .data_fifo_q          (data_fifo_q),
        .data_fifo_usedw      (data_fifo_usedw),
        .data_fifo_rdreq      (data_fifo_rdreq),
        .ddr3_buffer0_offset  (ddr3_buffer0_offset),
        .ddr3_buffer1_offset  (ddr3_buffer1_offset),
        .clear_buffer0        (clear_buffer0),
        .clear_buffer1        (clear_buffer1),
        .ddr3_wr_buffer0_valid(ddr3_wr_buffer0_valid),
        .ddr3_wr_buffer1_valid(ddr3_wr_buffer1_valid),
        .frame_done           (frame_done),
        .ddr3_avl_ready       (ddr3_avl_ready),
        .ddr3_avl_burstbegin  (ddr3_avl_burstbegin),
        .ddr3_avl_write_req   (ddr3_avl_write_req),
        .ddr3_avl_size        (ddr3_avl_size),
        .ddr3_avl_addr        (ddr3_avl_addr),
        .ddr3_avl_wdata       (ddr3_avl_wdata),
        .ddr3_avl_be          (ddr3_avl_be)
    );

    // Show-ahead FIFO model: the initial thread owns wr_ptr/mem, the pop process owns rd_ptr.
    logic [31:0] mem [0:4095];
    logic [11:0] wr_ptr = '0;
    logic [11:0] rd_ptr = '0;

    assign data_fifo_q     = mem[rd_ptr];
    assign data_fifo_usedw = wr_ptr - rd_ptr;

    always @(posedge ddr3_clk) begin
        if (ddr3_reset) rd_ptr <= wr_ptr;
        else if (data_fifo_rdreq) rd_ptr <= rd_ptr + 12'd1;
    end

    // Every beat the slave will accept: {burstbegin, addr, wdata}.
    logic [58:0] beats[$];
    always @(negedge ddr3_clk) begin
        if (ddr3_avl_write_req === 1'b1 && ddr3_avl_ready === 1'b1)
            beats.push_back({ddr3_avl_burstbegin, ddr3_avl_addr, ddr3_avl_wdata});
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] frame_words[$];
    int          beat_base;
    logic [11:0] rd_base;

    task automatic push_word();
        logic [31:0] w;
        w = $urandom;
        mem[wr_ptr] = w;
        frame_words.push_back(w);
        wr_ptr = wr_ptr + 12'd1;
    endtask

    task automatic start_frame();
        frame_words.delete();
        beat_base = beats.size();
        rd_base   = rd_ptr;
    endtask

    // Runs one frame to completion and checks it against the expected layout:
    // beat k goes to off + 4*(k/4), carries the k-th pushed word, burstbegin on k%4==0.
    task automatic do_frame(input logic [25:0] off, input int bsel, input int npre,
                            input bit rand_ready, input bit clr_on_done);
        int          pushed;
        bit          done;
        logic [25:0] ea;
        logic [58:0] exp_b;
        logic        vflag;
        pushed = npre;
        done   = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(posedge ddr3_clk); #1;
            ddr3_avl_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pushed < FRAME_WORDS) begin
                int n;
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) begin
                    if (pushed < FRAME_WORDS) begin
                        push_word();
                        pushed++;
                    end
                end
            end
            @(negedge ddr3_clk);
            if (frame_done === 1'b1) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL frame_timeout: got frame_done=0 after 4000 cycles, need 1 (buffer %0d)", bsel);
        end
        if (clr_on_done) begin
            if (bsel == 0) clear_buffer0 = 1'b1;
            else clear_buffer1 = 1'b1;
        end
        @(posedge ddr3_clk); #1;
        clear_buffer0 = 1'b0;
        clear_buffer1 = 1'b0;
        @(negedge ddr3_clk);
        total++;
        if (frame_done !== 1'b0) begin
            bad++;
            $display("FAIL frame_done_width: got %b, need 0", frame_done);
        end
        vflag = (bsel == 0) ? ddr3_wr_buffer0_valid : ddr3_wr_buffer1_valid;
        total++;
        if (vflag !== 1'b1) begin
            bad++;
            $display("FAIL valid_set buf%0d: got %b, need 1", bsel, vflag);
        end
        total++;
        if ((rd_ptr - rd_base) !== 12'(FRAME_WORDS)) begin
            bad++;
            $display("FAIL pop_count: got %0d, need %0d", rd_ptr - rd_base, FRAME_WORDS);
        end
        total++;
        if (beats.size() - beat_base != FRAME_WORDS) begin
            bad++;
            $display("FAIL beat_count: got %0d, need %0d", beats.size() - beat_base, FRAME_WORDS);
        end
        for (int k = 0; k < FRAME_WORDS; k++) begin
            ea    = off + 26'(4 * (k / 4));
            exp_b = {(k % 4 == 0), ea, frame_words[k]};
            total++;
            if (beat_base + k >= beats.size()) begin
                bad++;
                $display("FAIL beat%0d missing: got none, need %h", k, exp_b);
            end else if (beats[beat_base + k] !== exp_b) begin
                bad++;
                $display("FAIL beat%0d {bb,addr,data}: got %h, need %h", k, beats[beat_base + k], exp_b);
            end
        end
    endtask

    task automatic test_reset();
        ddr3_reset          = 1'b1;
        ddr3_avl_ready      = 1'b1;
        clear_buffer0       = 1'b0;
        clear_buffer1       = 1'b0;
        ddr3_buffer0_offset = 26'h0;
        ddr3_buffer1_offset = 26'h100;
        repeat (3) @(posedge ddr3_clk);
        @(negedge ddr3_clk);
        total++;
        if ({ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, frame_done,
             ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags {wr,bb,rd,fd,v0,v1}: got %b, need 000000",
                     {ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, frame_done,
                      ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid});
        end
        total++;
        if (ddr3_avl_addr !== 26'h0) begin
            bad++;
            $display("FAIL reset_addr: got %h, need 0", ddr3_avl_addr);
        end
        total++;
        if (ddr3_avl_size !== 3'b100 || ddr3_avl_be !== 4'hF) begin
            bad++;
            $display("FAIL const_size_be: got %b/%h, need 100/f", ddr3_avl_size, ddr3_avl_be);
        end
        @(posedge ddr3_clk); #1;
        ddr3_reset    = 1'b0;
        clear_buffer0 = 1'b1;
        @(posedge ddr3_clk); #1;
        clear_buffer0 = 1'b0;
        @(negedge ddr3_clk);
        total++;
        if (ddr3_wr_buffer0_valid !== 1'b0 || ddr3_avl_write_req !== 1'b0) begin
            bad++;
            $display("FAIL clear_noop {v0,wr}: got %b%b, need 00", ddr3_wr_buffer0_valid, ddr3_avl_write_req);
        end
    endtask

    task automatic test_first_frame();
        @(posedge ddr3_clk); #1;
        start_frame();
        for (int i = 0; i < FRAME_WORDS; i++) push_word();
        do_frame(26'h0, 0, FRAME_WORDS, 1'b0, 1'b0);
    endtask

    task automatic test_usedw_threshold();
        @(posedge ddr3_clk); #1;
        ddr3_avl_ready = 1'b0;
        start_frame();
        for (int i = 0; i < 3; i++) push_word();
        for (int i = 0; i < 4; i++) begin
            @(negedge ddr3_clk);
            total++;
            if (ddr3_avl_write_req !== 1'b0) begin
                bad++;
                $display("FAIL usedw3_no_req cycle %0d: got %b, need 0", i, ddr3_avl_write_req);
            end
        end
        @(posedge ddr3_clk); #1;
        push_word();
        @(negedge ddr3_clk);
        total++;
        if (ddr3_avl_write_req !== 1'b0) begin
            bad++;
            $display("FAIL usedw4_same_cycle: got %b, need 0", ddr3_avl_write_req);
        end
        @(negedge ddr3_clk);
        total++;
        if ({ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, ddr3_avl_addr, ddr3_avl_wdata}
            !== {1'b1, 1'b1, 1'b0, 26'h100, frame_words[0]}) begin
            bad++;
            $display("FAIL usedw4_req_rise {wr,bb,rd,addr,data}: got %b%b%b %h %h, need 110 0000100 %h",
                     ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, ddr3_avl_addr,
                     ddr3_avl_wdata, frame_words[0]);
        end
    endtask

    task automatic test_stall();
        @(posedge ddr3_clk); #1;
        ddr3_avl_ready = 1'b1;
        @(negedge ddr3_clk);
        total++;
        if (data_fifo_rdreq !== 1'b1) begin
            bad++;
            $display("FAIL stall_beat0_pop: got %b, need 1", data_fifo_rdreq);
        end
        @(posedge ddr3_clk); #1;
        ddr3_avl_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ddr3_clk);
            total++;
            if ({ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, ddr3_avl_addr, ddr3_avl_wdata}
                !== {1'b1, 1'b0, 1'b0, 26'h100, frame_words[1]}) begin
                bad++;
                $display("FAIL stall_hold cycle %0d: got %b%b%b %h %h, need 100 0000100 %h", i,
                         ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, ddr3_avl_addr,
                         ddr3_avl_wdata, frame_words[1]);
            end
            @(posedge ddr3_clk); #1;
        end
        ddr3_avl_ready = 1'b1;
        do_frame(26'h100, 1, 4, 1'b1, 1'b0);
    endtask

    task automatic test_both_valid();
        @(posedge ddr3_clk); #1;
        start_frame();
        for (int i = 0; i < 8; i++) push_word();
        ddr3_avl_ready = 1'b1;
`ifdef WR_FRAME_OVERWRITE_EN
        @(negedge ddr3_clk);
        total++;
        if ({ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid} !== 2'b10) begin
            bad++;
            $display("FAIL overwrite_drop {v0,v1}: got %b%b, need 10", ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid);
        end
        @(negedge ddr3_clk);
        total++;
        if (ddr3_avl_write_req !== 1'b1 || ddr3_avl_addr !== 26'h100) begin
            bad++;
            $display("FAIL overwrite_no_stall {wr,addr}: got %b %h, need 1 0000100", ddr3_avl_write_req, ddr3_avl_addr);
        end
        do_frame(26'h100, 1, 8, 1'b1, 1'b1);
`else
        for (int i = 0; i < 10; i++) begin
            @(negedge ddr3_clk);
            total++;
            if ({ddr3_avl_write_req, data_fifo_rdreq, ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid} !== 4'b0011) begin
                bad++;
                $display("FAIL both_valid_idle {wr,rd,v0,v1} cycle %0d: got %b%b%b%b, need 0011", i,
                         ddr3_avl_write_req, data_fifo_rdreq, ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid);
            end
        end
        @(posedge ddr3_clk); #1;
        clear_buffer0 = 1'b1;
        @(posedge ddr3_clk); #1;
        clear_buffer0 = 1'b0;
        @(negedge ddr3_clk);
        total++;
        if ({ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid} !== 2'b01) begin
            bad++;
            $display("FAIL clear0 {v0,v1}: got %b%b, need 01", ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid);
        end
        do_frame(26'h0, 0, 8, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        @(posedge ddr3_clk); #1;
        clear_buffer1 = 1'b1;
        @(posedge ddr3_clk); #1;
        clear_buffer1 = 1'b0;
        start_frame();
        for (int i = 0; i < 6; i++) push_word();
        ddr3_avl_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ddr3_clk);
            if (ddr3_avl_write_req === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL mid_burst_start: got write_req=0 after 20 cycles, need 1");
        end
        @(posedge ddr3_clk); #1;
        ddr3_reset = 1'b1;
        #1;
        total++;
        if ({ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, frame_done,
             ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid, ddr3_avl_addr} !== 32'h0) begin
            bad++;
            $display("FAIL mid_reset_outputs {wr,bb,rd,fd,v0,v1,addr}: got %b%b%b%b%b%b %h, need 000000 0000000",
                     ddr3_avl_write_req, ddr3_avl_burstbegin, data_fifo_rdreq, frame_done,
                     ddr3_wr_buffer0_valid, ddr3_wr_buffer1_valid, ddr3_avl_addr);
        end
        ddr3_buffer0_offset = 26'h3FFFFF8;
        repeat (2) @(posedge ddr3_clk);
        #1;
        ddr3_reset = 1'b0;
        start_frame();
        do_frame(26'h3FFFFF8, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_usedw_threshold();
        test_stall();
        test_both_valid();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
